// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: round-robin single-port RAM arbiter with burst lock and read-return routing.
// Define MEM_SCHED_STATS_EN to add the D_BUSYCNT / D_SWITCHCNT statistics outputs.
module mem_port_scheduler #(
    parameter int NREQ      = 4,
    parameter int AW        = 14,
    parameter int DW        = 10,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      ram_addr,
    output logic               ram_read,
    output logic               ram_write,
    output logic [DW-1:0]      ram_wdata,
    input  logic [DW-1:0]      ram_rdata,
    output logic               D_STATE,
    output logic [2:0]         D_OWNER,
    output logic [3:0]         D_BEATCNT
`ifdef MEM_SCHED_STATS_EN
    ,
    output logic [15:0]        D_BUSYCNT,
    output logic [15:0]        D_SWITCHCNT
`endif
);
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;
    state_t state, state_nx;
    logic [NREQ-1:0] grant_nx;
    logic [NREQ-1:0] rpipe [RD_LAT];
    logic [2:0] owner, owner_nx, last, last_nx, win;
    logic [3:0] cnt, cnt_nx;
    logic beat, lk, others, rel;

    // First set request after 'from', wrapping; 'from' itself has lowest priority.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] from);
        logic [2*NREQ-1:0] rot;
        rot = {r, r} >> (4'(from) + 4'd1);
        rr_pick = from;
        for (int j = NREQ - 1; j >= 0; j--)
            if (rot[j]) rr_pick = 3'((int'(from) + 1 + j) % NREQ);
    endfunction

    assign ack    = grant & req;
    assign beat   = |ack;
    assign others = |(req & ~grant);
    assign rel    = state == OWN && (!beat || !lk || (cnt == 4'(MAX_BURST - 1) && others));
    assign win    = rr_pick(req, rel ? owner : last);

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        lk        = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (ack[i]) begin
                ram_addr  = addr[i*AW +: AW];
                ram_wdata = wdata[i*DW +: DW];
                ram_write = we[i];
                ram_read  = ~we[i];
                lk        = lock[i];
            end
    end

    // Release hands the port straight to the next winner, so owners change without a bubble.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = cnt;
        if (state == IDLE || rel) begin
            if (rel) last_nx = owner;
            state_nx = |req ? OWN : IDLE;
            grant_nx = |req ? (NREQ'(1) << win) : '0;
            owner_nx = |req ? win : owner;
            cnt_nx   = '0;
        end else
            cnt_nx = cnt == 4'(MAX_BURST - 1) ? 4'd0 : cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            last  <= 3'(NREQ - 1);
            cnt   <= '0;
            for (int i = 0; i < RD_LAT; i++) rpipe[i] <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            owner    <= owner_nx;
            last     <= last_nx;
            cnt      <= cnt_nx;
            rpipe[0] <= ack & ~we;
            for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        end

    // Read tags travel with the RAM latency, so later grant changes cannot misroute data.
    assign rvalid    = rpipe[RD_LAT-1];
    assign rdata     = |rvalid ? ram_rdata : '0;
    assign D_STATE   = state;
    assign D_OWNER   = owner;
    assign D_BEATCNT = cnt;

`ifdef MEM_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            D_BUSYCNT   <= '0;
            D_SWITCHCNT <= '0;
        end else begin
            if (beat && D_BUSYCNT != 16'hFFFF) D_BUSYCNT <= D_BUSYCNT + 16'd1;
            if (rel && |req && win != owner && D_SWITCHCNT != 16'hFFFF) D_SWITCHCNT <= D_SWITCHCNT + 16'd1;
        end
`endif
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: directed and random stimulus against a behavioural arbitration model.
module tb_mem_port_scheduler;
    localparam int NREQ = 4, AW = 14, DW = 10, MAX_BURST = 8, RD_LAT = 1;

    logic clk = 1'b0, rst = 1'b0;
    logic [NREQ-1:0] req = '0, we = '0, lock = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0] grant, ack, rvalid, ack_s;
    logic [DW-1:0] rdata, ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW-1:0] ram_addr;
    logic ram_read, ram_write, D_STATE;
    logic [2:0] D_OWNER;
    logic [3:0] D_BEATCNT;
`ifdef MEM_SCHED_STATS_EN
    logic [15:0] D_BUSYCNT, D_SWITCHCNT;
    int e_busy = 0, e_sw = 0;
`endif

    int passed = 0, total = 0, cyc = 0;
    int m_owner = -1, m_last = NREQ - 1, m_cnt = 0;
    int b1, at0, wraps, drops, prevc;
    logic [DW-1:0] ram [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    typedef struct {int due; int who; logic [DW-1:0] data;} rd_t;
    rd_t pend[$];

    mem_port_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
        .grant(grant), .ack(ack), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
        .ram_read(ram_read), .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .D_STATE(D_STATE), .D_OWNER(D_OWNER), .D_BEATCNT(D_BEATCNT)
`ifdef MEM_SCHED_STATS_EN
        , .D_BUSYCNT(D_BUSYCNT), .D_SWITCHCNT(D_SWITCHCNT)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) ram[ram_addr] <= ram_wdata;
        if (ram_read) ram_rdata <= ram[ram_addr];
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    function automatic int rr(logic [NREQ-1:0] r, int from);
        for (int k = 1; k <= NREQ; k++)
            if (r[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] eg, ea;
        logic [AW-1:0] a;
        logic b;
        int o;
        if (!rst) begin
            m_owner = -1; m_last = NREQ - 1; m_cnt = 0;
            pend.delete();
`ifdef MEM_SCHED_STATS_EN
            e_busy = 0; e_sw = 0;
`endif
            chk("rst_grant", grant, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_strobes", {ram_read, ram_write}, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_wdata", ram_wdata, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_state", D_STATE, 0);
            chk("rst_beatcnt", D_BEATCNT, 0);
        end else begin
            o = m_owner;
            eg = (o < 0) ? '0 : NREQ'(1) << o;
            ea = eg & req;
            b = ea != 0;
            a = '0;
            chk("grant", grant, eg);
            chk("ack", ack, ea);
            if (b) begin
                a = addr[o*AW +: AW];
                chk("ram_read", ram_read, !we[o]);
                chk("ram_write", ram_write, we[o]);
                chk("ram_addr", ram_addr, a);
                chk("ram_wdata", ram_wdata, wdata[o*DW +: DW]);
            end else begin
                chk("ram_read", ram_read, 0);
                chk("ram_write", ram_write, 0);
                chk("ram_addr", ram_addr, 0);
                chk("ram_wdata", ram_wdata, 0);
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                chk("rvalid", rvalid, NREQ'(1) << pend[0].who);
                chk("rdata", rdata, pend[0].data);
                void'(pend.pop_front());
            end else begin
                chk("rvalid", rvalid, 0);
                chk("rdata", rdata, 0);
            end
            chk("state", D_STATE, m_owner >= 0);
            chk("beatcnt", D_BEATCNT, m_cnt);
            if (m_owner >= 0) chk("owner", D_OWNER, m_owner);
`ifdef MEM_SCHED_STATS_EN
            chk("busycnt", D_BUSYCNT, e_busy);
            chk("switchcnt", D_SWITCHCNT, e_sw);
            if (b) e_busy++;
`endif
            if (b) begin
                if (we[o]) ref_mem[a] = wdata[o*DW +: DW];
                else pend.push_back('{due: cyc + RD_LAT, who: o, data: ref_mem[a]});
            end
            if (o < 0) begin
                if (req != 0) begin m_owner = rr(req, m_last); m_cnt = 0; end
            end else if (!b || !lock[o] || (m_cnt == MAX_BURST - 1 && (req & ~eg) != 0)) begin
                m_last = o;
                m_owner = (req != 0) ? rr(req, o) : -1;
                m_cnt = 0;
`ifdef MEM_SCHED_STATS_EN
                if (m_owner >= 0 && m_owner != o) e_sw++;
`endif
            end else m_cnt = (m_cnt + 1) % MAX_BURST;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(int i, logic r, logic w, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
        req[i] = r; we[i] = w; lock[i] = l;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_ack(int i, string nm);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack[i]) break;
            step();
        end
        chk(nm, ack[i], 1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = DW'(i * 3 + 1);
            ref_mem[i] = DW'(i * 3 + 1);
        end
        repeat (3) step();
        rst = 1'b1;
        // single master, two reads, lock then unlock
        step(); set_m(2, 1, 0, 1, 14'h0010, '0);
        @(negedge clk); chk("t1_wait", grant, 0);
        step();
        @(negedge clk); chk("t1_grant", grant, 4'b0100); chk("t1_addr0", ram_addr, 14'h0010);
        step(); set_m(2, 1, 0, 0, 14'h0011, '0);
        @(negedge clk); chk("t1_rv0", rvalid, 4'b0100); chk("t1_rd0", rdata, 10'h031);
        step(); req = '0;
        @(negedge clk); chk("t1_rv1", rvalid, 4'b0100); chk("t1_rd1", rdata, 10'h034);
        repeat (2) step();
        @(negedge clk); chk("t1_idle", D_STATE, 0);
        // all four request unlocked from reset
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        step(); req = 4'b1111; we = '0; lock = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk); chk("t2_rr", grant, 4'b0001 << (k % 4));
        end
        step(); req = '0;
        repeat (2) step();
        // locked burst preempted at MAX_BURST
        b1 = 0; at0 = -1;
        set_m(0, 0, 0, 0, 14'h0020, '0);
        set_m(1, 1, 0, 1, 14'h0030, '0);
        for (int k = 0; k < 100 && b1 < 20; k++) begin
            @(negedge clk);
            if (ack[1]) b1++;
            if (ack[0]) at0 = b1;
            step();
            req[1] = b1 < 20;
            req[0] = b1 >= 3 && at0 < 0;
        end
        chk("t3_beats", b1, 20);
        chk("t3_preempt", at0, 8);
        repeat (2) step();
        // locked alone: grant held, count wraps
        b1 = 0; wraps = 0; drops = 0; prevc = -1;
        set_m(1, 1, 0, 1, 14'h0040, '0);
        for (int k = 0; k < 60 && b1 < 20; k++) begin
            @(negedge clk);
            if (ack[1]) begin
                if (prevc == 7 && D_BEATCNT == 0) wraps++;
                prevc = D_BEATCNT;
                b1++;
            end else if (b1 > 0) drops++;
            step();
            req[1] = b1 < 20;
        end
        chk("t4_beats", b1, 20);
        chk("t4_wraps", wraps, 2);
        chk("t4_nodrop", drops, 0);
        repeat (2) step();
        // reset right after a read beat
        set_m(0, 1, 0, 0, 14'h0123, '0);
        wait_ack(0, "t5_ack");
        step(); rst = 1'b0; req = '0;
        @(negedge clk); chk("t5_grant", grant, 0); chk("t5_rvalid", rvalid, 0); chk("t5_read", ram_read, 0);
        step(); rst = 1'b1;
        step(); req = 4'b1010; we = '0; lock = '0;
        step();
        @(negedge clk); chk("t5_rr", grant, 4'b0010);
        step(); req = '0;
        repeat (2) step();
        // write from master 3, read back by master 0
        set_m(3, 1, 1, 0, 14'h3FFF, 10'h2A5);
        wait_ack(3, "t6_wack");
        chk("t6_write", ram_write, 1); chk("t6_waddr", ram_addr, 14'h3FFF); chk("t6_wdata", ram_wdata, 10'h2A5);
        step(); req = '0; set_m(0, 1, 0, 0, 14'h3FFF, '0);
        wait_ack(0, "t6_rack");
        step(); req = '0;
        @(negedge clk); chk("t6_rv", rvalid, 4'b0001); chk("t6_rd", rdata, 10'h2A5);
        repeat (2) step();
        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); ack_s = ack;
            step();
            rst = $urandom_range(399) != 0;
            for (int i = 0; i < NREQ; i++)
                if (!(req[i] && !ack_s[i] && $urandom_range(15) != 0)) begin
                    if ($urandom_range(2) != 0)
                        set_m(i, 1, 1'($urandom), 1'($urandom), AW'($urandom_range(63)), DW'($urandom));
                    else req[i] = 1'b0;
                end
        end
        step(); rst = 1'b1; req = '0;
        repeat (4) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
